// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: walks a small program table, programming one divider channel per
// entry, waiting for the divider to settle, then dwelling for N rises of the divided clock.
module clk_div_sequencer #(
   parameter  int DEPTH         = 4,
   parameter  int SETTLE_CYCLES = 130,
   localparam int AW            = $clog2(DEPTH),
   localparam int SW            = $clog2(SETTLE_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] n_steps,
   input  logic          loop_en,
   input  logic          start,
   input  logic          stop,
   input  logic          div_in,
   output logic [25:0]   cfg_out,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_step
);
   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [15:0]   tbl [DEPTH];
   logic [15:0]   entry;
   logic [AW-1:0] n_lat;
   logic          loop_lat, div_q, rise, settle_last, step_end;
   logic [SW-1:0] settle_cnt;
   logic [8:0]    edge_cnt, dwell_tgt;

   assign entry       = tbl[cur_step];
   assign rise        = div_in & ~div_q;
   assign settle_last = settle_cnt == SW'(SETTLE_CYCLES - 1);
   // dwell of 0 means 256 edges
   assign dwell_tgt   = {~|entry[15:8], entry[15:8]};
   assign step_end    = state == RUN && rise && edge_cnt + 9'd1 == dwell_tgt;

   always_ff @(posedge clk)
      if (wr_en && state == IDLE) tbl[wr_addr] <= wr_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? APPLY : IDLE;
         APPLY:   state_nxt = SETTLE;
         SETTLE:  state_nxt = settle_last ? RUN : SETTLE;
         RUN:     state_nxt = !step_end ? RUN : (cur_step < n_lat || loop_lat) ? APPLY : DONE;
         default: state_nxt = IDLE;
      endcase
      if (stop) state_nxt = IDLE;
   end

   always_comb begin
      busy = state == APPLY || state == SETTLE || state == RUN;
      done = state == DONE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cfg_out    <= '0;
         cur_step   <= '0;
         n_lat      <= '0;
         loop_lat   <= 1'b0;
         div_q      <= 1'b0;
         settle_cnt <= '0;
         edge_cnt   <= '0;
      end else begin
         div_q      <= div_in;
         settle_cnt <= state == SETTLE ? settle_cnt + 1'b1 : '0;
         edge_cnt   <= state != RUN ? '0 : (rise && !(&edge_cnt)) ? edge_cnt + 9'd1 : edge_cnt;
         if (state == IDLE && start && !stop) begin
            n_lat    <= n_steps;
            loop_lat <= loop_en;
            cur_step <= '0;
         end
         // only the selected channel's factor changes; the other three are held
         if (state == APPLY && !stop) begin
            cfg_out[1:0]                  <= entry[1:0];
            cfg_out[2 + 6*entry[1:0] +: 6] <= entry[7:2];
         end
         if (state == RUN && state_nxt == APPLY) cur_step <= cur_step < n_lat ? cur_step + 1'b1 : '0;
      end
endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb_clk_div_sequencer: random-stimulus bench; a table-level reference model predicts every
// visible output change (cycle, cfg, step, busy, done) into a queue that a monitor drains.
module tb_clk_div_sequencer;
   localparam int DEPTH = 4, SETTLE = 130, AW = 2, WN = 1 << 17;

   logic          clk = 1'b0, rst = 1'b1, wr_en = 1'b0, loop_en = 1'b0;
   logic          start = 1'b0, stop = 1'b0, div_in = 1'b0;
   logic [AW-1:0] wr_addr = '0, n_steps = '0;
   logic [15:0]   wr_data = '0;
   logic [25:0]   cfg_out;
   logic          busy, done;
   logic [AW-1:0] cur_step;

   int cyc = 0, n_chk = 0, n_fail = 0;
   bit wave [WN];

   typedef struct {
      int            e;
      logic [25:0]   cfg;
      logic [AW-1:0] step;
      logic          busy;
      logic          done;
   } ev_t;
   ev_t q[$];
   ev_t last, mon_x;

   logic [5:0]    m_f [4];
   logic [1:0]    m_sel;
   logic [AW-1:0] m_step;
   logic          m_busy, m_done;
   logic [15:0]   tbl [DEPTH] = '{default: 16'h0};
   logic [AW+27:0] mon_prev = '0;

   int s0, f0, lp_r, so_r;

   clk_div_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .n_steps(n_steps), .loop_en(loop_en), .start(start), .stop(stop), .div_in(div_in),
      .cfg_out(cfg_out), .busy(busy), .done(done), .cur_step(cur_step)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // value sampled at posedge number e is wave[e]
   always @(negedge clk) div_in = wave[(cyc + 1) % WN];

   function automatic bit w(input int e);
      return wave[e % WN];
   endfunction

   function automatic void gen_wave();
      for (int c = 0; c < WN / 64; c++) begin
         automatic int md = $urandom_range(0, 2);
         automatic int p  = $urandom_range(1, 4);
         for (int k = 0; k < 64; k++) begin
            automatic int i = c * 64 + k;
            wave[i] = md == 0 ? 1'($urandom) : 1'((i / p) % 2);
         end
      end
   endfunction

   function automatic logic [15:0] ent(input int dwell, input int f, input int ch);
      return {8'(dwell), 6'(f), 2'(ch)};
   endfunction

   function automatic logic [15:0] rnd_ent();
      return ent($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6), $urandom_range(0, 63), $urandom_range(0, 3));
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_f    = '{default: 6'd0};
      m_sel  = 2'd0;
      m_step = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      last   = '{e: 0, cfg: 26'd0, step: '0, busy: 1'b0, done: 1'b0};
      q.delete();
   endtask

   task automatic push(input int e);
      ev_t x;
      x.e    = e;
      x.cfg  = {m_f[3], m_f[2], m_f[1], m_f[0], m_sel};
      x.step = m_step;
      x.busy = m_busy;
      x.done = m_done;
      if ({x.cfg, x.step, x.busy, x.done} != {last.cfg, last.step, last.busy, last.done}) q.push_back(x);
      last = x;
   endtask

   // program started by the edge s; optional stop sampled at edge t (0 = none)
   task automatic predict(input int s, input int n, input bit lp, input int t, output int fin);
      int a, e, cnt, tgt, i, cut;
      logic [15:0] en;
      cut = t == 0 ? 32'h7fffffff : t;
      m_step = '0;
      m_busy = 1'b1;
      push(s);
      fin = s;
      i = 0;
      a = s + 1;
      forever begin
         if (a >= cut) break;
         en = tbl[i];
         m_sel = en[1:0];
         m_f[en[1:0]] = en[7:2];
         push(a);
         fin = a;
         tgt = en[15:8] == 0 ? 256 : int'(en[15:8]);
         e = a + SETTLE;
         cnt = 0;
         while (cnt < tgt && e < cut) begin
            e++;
            if (w(e) && !w(e - 1)) cnt++;
         end
         if (cnt < tgt || e >= cut) break;
         if (i < n || lp) begin
            i = i < n ? i + 1 : 0;
            m_step = AW'(i);
            push(e);
            a = e + 1;
         end else begin
            m_busy = 1'b0;
            m_done = 1'b1;
            push(e);
            m_done = 1'b0;
            push(e + 1);
            fin = e + 1;
            return;
         end
      end
      m_busy = 1'b0;
      m_done = 1'b0;
      push(t);
      fin = t;
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      tbl[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // disturb: a write to entry 1 and a second start, both while busy, must be ignored
   task automatic run_prog(input int n, input bit lp, input int stop_off, input bit disturb);
      int s, t, fin;
      bit dis;
      @(negedge clk);
      s = cyc + 1;
      t = stop_off > 0 ? s + stop_off : 0;
      dis = disturb && (t == 0 || stop_off > 25);
      predict(s, n, lp, t, fin);
      if (t > fin) fin = t;
      n_steps = AW'(n);
      loop_en = lp;
      start = 1'b1;
      while (cyc < fin + 4) begin
         @(negedge clk);
         start   = dis && cyc + 1 == s + 20;
         wr_en   = start;
         wr_addr = AW'(1);
         wr_data = ~tbl[1];
         stop    = t != 0 && cyc + 1 == t;
         n_steps = AW'($urandom);
         loop_en = 1'($urandom);
      end
      start = 1'b0;
      stop  = 1'b0;
      wr_en = 1'b0;
      chk("queue_drained", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst) mon_prev = '0;
      else if ({cfg_out, cur_step, busy, done} != mon_prev) begin
         mon_prev = {cfg_out, cur_step, busy, done};
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: cycle %0d cfg %h step %0d busy %0d done %0d, none expected",
                     cyc, cfg_out, cur_step, busy, done);
         end else begin
            mon_x = q.pop_front();
            chk("ev_cycle", cyc, mon_x.e);
            chk("ev_cfg", cfg_out, mon_x.cfg);
            chk("ev_step", cur_step, mon_x.step);
            chk("ev_busy", busy, mon_x.busy);
            chk("ev_done", done, mon_x.done);
         end
      end
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      gen_wave();
      model_reset();
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom);
         stop = 1'($urandom);
         loop_en = 1'($urandom);
         n_steps = AW'($urandom);
         chk("rst_cfg", cfg_out, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_step", cur_step, 0);
      end
      start = 1'b0;
      stop = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      wr(0, ent(3, 5, 2));
      run_prog(0, 0, 0, 1);
      chk("single_fC", cfg_out[19:14], 5);
      chk("single_sel", cfg_out[1:0], 2);

      wr(0, ent(8, 0, 0));
      wr(1, ent(2, 10, 1));
      wr(2, ent(1, 63, 3));
      run_prog(2, 0, 0, 0);
      chk("seq_fA", cfg_out[7:2], 0);
      chk("seq_fB", cfg_out[13:8], 10);
      chk("seq_fC_held", cfg_out[19:14], 5);
      chk("seq_fD", cfg_out[25:20], 63);
      chk("seq_step", cur_step, 2);

      run_prog(2, 1, 1500, 1);
      run_prog(2, 0, 0, 0);
      chk("busy_write_ignored_fB", cfg_out[13:8], 10);

      wr(0, ent(0, 42, 1));
      run_prog(0, 0, 0, 0);
      chk("dwell0_fB", cfg_out[13:8], 42);

      @(negedge clk);
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_step", cur_step, m_step);
      @(negedge clk);
      chk("start_stop_busy2", busy, 0);

      for (int k = 0; k < 8; k++) begin
         for (int a = 0; a < DEPTH; a++) wr(a, rnd_ent());
         lp_r = $urandom_range(0, 1);
         so_r = lp_r != 0 ? $urandom_range(1, 1500) : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 600) : 0);
         run_prog($urandom_range(0, DEPTH - 1), lp_r != 0, so_r, $urandom_range(0, 1) != 0);
      end

      for (int a = 0; a < DEPTH; a++) wr(a, ent(0, a + 1, a));
      @(negedge clk);
      s0 = cyc + 1;
      predict(s0, 3, 0, 0, f0);
      n_steps = AW'(3);
      loop_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < s0 + 300) @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      start = 1'b1;
      stop = 1'b1;
      #1;
      chk("rst_async_cfg", cfg_out, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_done", done, 0);
      chk("rst_async_step", cur_step, 0);
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_busy", busy, 0);

      wr(0, ent(2, 7, 1));
      run_prog(0, 0, 0, 0);
      chk("recover_fB", cfg_out[13:8], 7);
      chk("recover_sel", cfg_out[1:0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
